// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-read-port register file with a self-clearing sweep.
//
// After reset (or on a clr request) the file walks every entry writing zero,
// one entry per clock, and only then reports ready. While clearing, every read
// returns zero and every write request is dropped. In READY one write per
// cycle is accepted; rejected write requests raise w_drop for one cycle.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a read port addressing the entry being written this cycle
//               returns w_data_reg combinationally (write-to-read bypass).
//   undefined : that port returns the pre-write value until the next cycle.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   r_addr_reg  in   read_ports*AW packed read addresses (port p at [p*AW +: AW])
//   r_data_reg  out  read_ports*data_length packed read data
//   w_addr_reg  in   write address
//   w_data_reg  in   write data
//   w_ctrl_reg  in   write request
//   clr         in   synchronous request to zero the whole file
//   ready       out  high when the FSM is in READY (also the FSM state view)
//   w_drop      out  one-cycle pulse: the previous cycle's write was discarded
//
// Handshake: w_ctrl_reg is a request with no back-pressure; it takes effect at
// the rising edge it is sampled on, or is discarded and reported via w_drop on
// the following cycle. There is no ready/valid stall; callers watch ready.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int register_count = 32,
    parameter int data_length    = 32,
    parameter int read_ports     = 3,
    parameter int zero_reg       = 1,
    localparam int AW = (register_count > 1) ? $clog2(register_count) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [read_ports*AW-1:0]          r_addr_reg,
    output logic [read_ports*data_length-1:0] r_data_reg,
    input  logic [AW-1:0]                     w_addr_reg,
    input  logic [data_length-1:0]            w_data_reg,
    input  logic                              w_ctrl_reg,
    input  logic                              clr,
    output logic                              ready,
    output logic                              w_drop
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Address limit compared one bit wider so a power-of-two count does not
    // collapse into a constant comparison.
    localparam logic [AW:0]   REG_LIMIT = (AW+1)'(register_count);
    localparam logic [AW-1:0] LAST_IDX  = AW'(register_count - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic              write_accept;
    logic              w_in_range;
    logic              w_is_zero_reg;

    logic [data_length-1:0] mem [register_count];

    // ------------------------------------------------------------------
    // Write qualification
    // ------------------------------------------------------------------
    assign w_in_range    = ({1'b0, w_addr_reg} < REG_LIMIT);
    assign w_is_zero_reg = (zero_reg == 1) && (w_addr_reg == '0);
    // clr wins over a same-cycle write.
    assign write_accept  = (state_q == READY) && !clr && w_ctrl_reg &&
                           w_in_range && !w_is_zero_reg;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            CLEAR: begin
                if (clr) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == LAST_IDX) begin
                    state_d   = READY;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            READY: begin
                if (clr) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    assign ready = (state_q == READY);

    // ------------------------------------------------------------------
    // Storage: no reset on the array; the sweep zeroes it entry by entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (write_accept) begin
            mem[w_addr_reg] <= w_data_reg;
        end
    end

    // ------------------------------------------------------------------
    // Dropped-write pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_drop <= 1'b0;
        end else begin
            w_drop <= w_ctrl_reg && !write_accept;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: combinational, independent
    // ------------------------------------------------------------------
    for (genvar p = 0; p < read_ports; p++) begin : g_rd
        logic [AW-1:0]          rd_addr;
        logic                   rd_ok;
        logic [data_length-1:0] rd_data;

        assign rd_addr = r_addr_reg[p*AW +: AW];
        assign rd_ok   = ({1'b0, rd_addr} < REG_LIMIT) &&
                         !((zero_reg == 1) && (rd_addr == '0));

        always_comb begin
            rd_data = '0;
            if ((state_q == READY) && rd_ok) begin
                rd_data = mem[rd_addr];
`ifdef REGFILE_BYPASS_EN
                if (write_accept && (rd_addr == w_addr_reg)) begin
                    rd_data = w_data_reg;
                end
`endif
            end
        end

        assign r_data_reg[p*data_length +: data_length] = rd_data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp (default parameters).
// Inputs are driven on the falling edge; combinational reads are checked
// just before the rising edge and registered outputs on the falling edge.
// The reference model tracks contents as a plain array, readiness as a
// countdown of remaining clear cycles, and zeroes the array when it ends.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int NP   = 3;
    localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic               clk;
    logic               rst;
    logic [NP*AW-1:0]   r_addr;
    logic [NP*DW-1:0]   r_data;
    logic [AW-1:0]      w_addr;
    logic [DW-1:0]      w_data;
    logic               w_ctrl;
    logic               clr;
    logic               ready;
    logic               w_drop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_mp #(
        .register_count(NREG),
        .data_length   (DW),
        .read_ports    (NP),
        .zero_reg      (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r_addr_reg(r_addr),
        .r_data_reg(r_data),
        .w_addr_reg(w_addr),
        .w_data_reg(w_data),
        .w_ctrl_reg(w_ctrl),
        .clr       (clr),
        .ready     (ready),
        .w_drop    (w_drop)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [NREG];
    bit            m_ready;
    int            m_left;
    bit            exp_drop;

    int n_checks;
    int n_pass;

    function automatic bit cur_accept();
        return m_ready && !clr && w_ctrl && (w_addr != 0);
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (!m_ready)   return '0;
        if (a == 0)     return '0;
        if (BYPASS && cur_accept() && (a == w_addr)) return w_data;
        return m_mem[a];
    endfunction

    // Advance one clock: update the model from the inputs seen at the edge,
    // then return at the following falling edge.
    task automatic step();
        bit acc;
        @(posedge clk);
        if (!rst) begin
            m_ready  = 1'b0;
            m_left   = NREG;
            exp_drop = 1'b0;
        end else begin
            acc      = cur_accept();
            exp_drop = w_ctrl && !acc;
            if (acc) m_mem[w_addr] = w_data;
            if (clr) begin
                m_ready = 1'b0;
                m_left  = NREG;
            end else if (!m_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_ports(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2);
        r_addr[0*AW +: AW] = a0;
        r_addr[1*AW +: AW] = a1;
        r_addr[2*AW +: AW] = a2;
    endtask

    task automatic idle_inputs();
        w_ctrl = 1'b0;
        clr    = 1'b0;
        w_addr = '0;
        w_data = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        rst = 1'b0;
        idle_inputs();
        set_ports(5'd5, 5'd0, 5'd31);
        step();
        n_checks++;
        if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready);
        else n_pass++;
        n_checks++;
        if (w_drop !== 1'b0) $display("FAIL reset_w_drop: got %b want 0", w_drop);
        else n_pass++;
        n_checks++;
        if (r_data !== '0) $display("FAIL reset_rdata: got %h want 0", r_data);
        else n_pass++;
        step();
        rst = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        n_checks++;
        if (n !== 32) $display("FAIL reset_ready_latency: got %0d cycles want 32", n);
        else n_pass++;
        for (int a = 0; a < NREG; a++) begin
            set_ports(a[AW-1:0], a[AW-1:0], a[AW-1:0]);
            #1;
            for (int p = 0; p < NP; p++) begin
                n_checks++;
                if (r_data[p*DW +: DW] !== 32'h0)
                    $display("FAIL post_clear_read: port %0d addr %0d got %h want 0",
                             p, a, r_data[p*DW +: DW]);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_directed_write();
        w_ctrl = 1'b1; w_addr = 5'd5; w_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        set_ports(5'd5, 5'd5, 5'd0);
        #1;
        n_checks++;
        if (r_data[0*DW +: DW] !== 32'hDEADBEEF)
            $display("FAIL x5_port0: got %h want deadbeef", r_data[0*DW +: DW]);
        else n_pass++;
        n_checks++;
        if (r_data[1*DW +: DW] !== 32'hDEADBEEF)
            $display("FAIL x5_port1: got %h want deadbeef", r_data[1*DW +: DW]);
        else n_pass++;
        n_checks++;
        if (r_data[2*DW +: DW] !== 32'h0)
            $display("FAIL x0_port2: got %h want 0", r_data[2*DW +: DW]);
        else n_pass++;
        step();
        w_ctrl = 1'b1; w_addr = 5'd0; w_data = 32'h1234;
        step();
        idle_inputs();
        n_checks++;
        if (w_drop !== 1'b1) $display("FAIL x0_drop_pulse: got %b want 1", w_drop);
        else n_pass++;
        set_ports(5'd0, 5'd5, 5'd0);
        #1;
        n_checks++;
        if (r_data[0*DW +: DW] !== 32'h0)
            $display("FAIL x0_after_write: got %h want 0", r_data[0*DW +: DW]);
        else n_pass++;
        step();
        n_checks++;
        if (w_drop !== 1'b0) $display("FAIL x0_drop_one_cycle: got %b want 0", w_drop);
        else n_pass++;
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want;
        w_ctrl = 1'b1; w_addr = 5'd7; w_data = 32'hA5A5A5A5;
        set_ports(5'd0, 5'd7, 5'd5);
        #1;
        want = BYPASS ? 32'hA5A5A5A5 : 32'h0;
        n_checks++;
        if (r_data[1*DW +: DW] !== want)
            $display("FAIL same_cycle_read_x7: got %h want %h", r_data[1*DW +: DW], want);
        else n_pass++;
        n_checks++;
        if (r_data[2*DW +: DW] !== 32'hDEADBEEF)
            $display("FAIL unrelated_port_x5: got %h want deadbeef", r_data[2*DW +: DW]);
        else n_pass++;
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (r_data[1*DW +: DW] !== 32'hA5A5A5A5)
            $display("FAIL next_cycle_read_x7: got %h want a5a5a5a5", r_data[1*DW +: DW]);
        else n_pass++;
        step();
    endtask

    task automatic test_random();
        logic [DW-1:0] want;
        for (int c = 0; c < 400; c++) begin
            w_ctrl = 1'($urandom_range(0, 1));
            w_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3))
                                                 : AW'($urandom_range(0, NREG - 1));
            w_data = $urandom;
            clr    = ($urandom_range(0, 79) == 0);
            for (int p = 0; p < NP; p++)
                r_addr[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? w_addr
                                                                 : AW'($urandom_range(0, NREG - 1));
            #1;
            for (int p = 0; p < NP; p++) begin
                want = model_rd(r_addr[p*AW +: AW]);
                n_checks++;
                if (r_data[p*DW +: DW] !== want)
                    $display("FAIL rand_read: cycle %0d port %0d addr %0d got %h want %h",
                             c, p, r_addr[p*AW +: AW], r_data[p*DW +: DW], want);
                else n_pass++;
            end
            step();
            n_checks++;
            if (w_drop !== exp_drop)
                $display("FAIL rand_w_drop: cycle %0d got %b want %b", c, w_drop, exp_drop);
            else n_pass++;
            n_checks++;
            if (ready !== m_ready)
                $display("FAIL rand_ready: cycle %0d got %b want %b", c, ready, m_ready);
            else n_pass++;
        end
        idle_inputs();
        // Let any clear started by the random phase finish.
        for (int i = 0; i < 40 && !m_ready; i++) step();
    endtask

    task automatic test_clear_collision();
        int low;
        for (int a = 1; a < NREG; a++) begin
            w_ctrl = 1'b1; w_addr = a[AW-1:0]; w_data = a;
            step();
        end
        idle_inputs();
        set_ports(5'd1, 5'd17, 5'd31);
        #1;
        n_checks++;
        if (r_data !== {32'd31, 32'd17, 32'd1})
            $display("FAIL fill_readback: got %h want %h", r_data, {32'd31, 32'd17, 32'd1});
        else n_pass++;
        step();
        clr = 1'b1; w_ctrl = 1'b1; w_addr = 5'd3; w_data = 32'h55;
        step();
        idle_inputs();
        n_checks++;
        if (w_drop !== 1'b1) $display("FAIL clr_write_drop: got %b want 1", w_drop);
        else n_pass++;
        low = 0;
        while (!ready && low < 100) begin
            low++;
            step();
        end
        n_checks++;
        if (low !== 32) $display("FAIL clr_ready_low: got %0d cycles want 32", low);
        else n_pass++;
        set_ports(5'd3, 5'd31, 5'd1);
        #1;
        n_checks++;
        if (r_data !== '0) $display("FAIL x3_after_clear: got %h want 0", r_data);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        w_ctrl = 1'b1; w_addr = 5'd4; w_data = 32'hCAFE0004;
        step();
        idle_inputs();
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || w_drop !== 1'b0)
            $display("FAIL mid_sweep_reset: got ready=%b w_drop=%b want 0/0", ready, w_drop);
        else n_pass++;
        step();
        step();
        rst = 1'b1;
        w_ctrl = 1'b1; w_addr = 5'd4; w_data = 32'h4444;
        step();
        idle_inputs();
        n = 1;
        n_checks++;
        if (w_drop !== 1'b1) $display("FAIL clear_write_drop: got %b want 1", w_drop);
        else n_pass++;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        n_checks++;
        if (n !== 32) $display("FAIL restart_ready_latency: got %0d cycles want 32", n);
        else n_pass++;
        set_ports(5'd4, 5'd4, 5'd7);
        #1;
        n_checks++;
        if (r_data !== '0) $display("FAIL x4_after_restart: got %h want 0", r_data);
        else n_pass++;
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_ready  = 1'b0;
        m_left   = NREG;
        exp_drop = 1'b0;
        rst      = 1'b0;
        r_addr   = '0;
        idle_inputs();
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
        @(negedge clk);
        test_reset();
        test_directed_write();
        test_bypass();
        test_random();
        test_clear_collision();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
